fetch_ctrl_seq: RTL and testbench

//  Fetch/execute sequencer directly upstream of the instruction register.

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/ctrl_pc.sv | 18 +
 rtl/fetch_ctrl_seq.sv | 82 ++++++++
 tb/tb_fetch_ctrl_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, fetch capture codes and state encoding for fetch_ctrl_seq
package ctrl_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_HLT   = 3'd7;
  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_REG  = 2'b01;
  localparam logic [1:0] FETCH_MEM  = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_F1_REQ, S_F1_CAP, S_F2_REQ, S_F2_CAP,
    S_EXEC, S_LD_MEM, S_ST_MEM, S_WB, S_HALT, S_ERR
  } state_e;
endpackage

// File: rtl/ctrl_pc.sv
// ctrl_pc: 8-bit program counter with increment and load (load wins)
module ctrl_pc #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] addr_i,
  output logic [7:0] pc_o
);
  logic [7:0] pc_d, pc_q;
  always_comb pc_d = load_i ? addr_i : inc_i ? pc_q + 8'd1 : pc_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_ctrl_seq.sv
// fetch_ctrl_seq: two-word fetch/execute sequencer driving the instruction register.
// Define CTRL_TIMEOUT_EN to add the mem_ready watchdog (WAIT_MAX cycles -> ERR).
module fetch_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
`ifdef CTRL_TIMEOUT_EN
  , parameter int WAIT_MAX = 15
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ins,
  input  logic [7:0] op_addr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] fetch,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_addr,
  output logic [7:0] pc,
  output logic       alu_en,
  output logic       alu_sub,
  output logic       reg_wr,
  output logic       busy,
  output logic       halt,
  output logic       err
);
  state_e state_q;
  logic   waiting, fetching, exec, jump, timeout;
  assign waiting  = state_q inside {S_F1_REQ, S_F2_REQ, S_LD_MEM, S_ST_MEM};
  assign fetching = state_q inside {S_F1_REQ, S_F1_CAP, S_F2_REQ, S_F2_CAP};
  assign exec     = state_q == S_EXEC;
  assign jump     = exec && (ins == OP_JMP || (ins == OP_JZ && zero));
`ifdef CTRL_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q;
  assign timeout = waiting && !mem_ready && cnt_q == CW'(WAIT_MAX - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= (!waiting || mem_ready) ? '0 : cnt_q + CW'(1);
  assign err = state_q == S_ERR;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IDLE;
    else if (timeout) state_q <= S_ERR;
    else
      case (state_q)
        S_IDLE:   if (start) state_q <= S_F1_REQ;
        S_F1_REQ: if (mem_ready) state_q <= S_F1_CAP;
        S_F1_CAP: state_q <= S_F2_REQ;
        S_F2_REQ: if (mem_ready) state_q <= S_F2_CAP;
        S_F2_CAP: state_q <= S_EXEC;
        S_EXEC:   state_q <= ins == OP_LOAD ? S_LD_MEM : ins == OP_STORE ? S_ST_MEM :
                             ins == OP_HLT ? S_HALT : S_F1_REQ;
        S_LD_MEM: if (mem_ready) state_q <= S_WB;
        S_ST_MEM: if (mem_ready) state_q <= S_F1_REQ;
        S_WB:     state_q <= S_F1_REQ;
        default:  state_q <= state_q;
      endcase
  ctrl_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (state_q == S_F1_CAP || state_q == S_F2_CAP),
    .load_i (jump),
    .addr_i (op_addr),
    .pc_o   (pc)
  );
  assign fetch    = state_q == S_F1_CAP ? FETCH_REG : state_q == S_F2_CAP ? FETCH_MEM : FETCH_NONE;
  assign mem_rd   = fetching || state_q == S_LD_MEM;
  assign mem_wr   = state_q == S_ST_MEM;
  assign mem_addr = fetching ? pc : (state_q inside {S_LD_MEM, S_ST_MEM}) ? op_addr : 8'h00;
  assign alu_en   = exec && (ins == OP_ADD || ins == OP_SUB);
  assign alu_sub  = exec && ins == OP_SUB;
  assign reg_wr   = alu_en || state_q == S_WB;
  assign busy     = !(state_q inside {S_IDLE, S_HALT});
  assign halt     = state_q == S_HALT;
endmodule

// File: tb/tb_fetch_ctrl_seq.sv
// tb_fetch_ctrl_seq: random and directed programs checked against an instruction-level model
module tb_fetch_ctrl_seq;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [2:0] ins = 3'd0;
  logic [7:0] op_addr = 8'h00;
  logic [1:0] fetch;
  logic       mem_rd, mem_wr, alu_en, alu_sub, reg_wr, busy, halt, err;
  logic [7:0] mem_addr, pc;
  logic [7:0] mem [256];
  logic [7:0] pc_m = 8'h00;
  int         checks = 0, failures = 0, dly = 0, wcnt = 0;
  bit         hold = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl_seq #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .ins(ins), .op_addr(op_addr), .zero(zero),
    .mem_ready(mem_ready), .fetch(fetch), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .pc(pc), .alu_en(alu_en), .alu_sub(alu_sub), .reg_wr(reg_wr),
    .busy(busy), .halt(halt), .err(err)
  );

  // Memory responder (ready after dly wait cycles per request) and instruction register
  always @(negedge clk) begin
    if (!rst) begin
      wcnt = 0;
      mem_ready = 1'b0;
    end else if ((mem_rd || mem_wr) && fetch == 2'b00 && !hold) begin
      mem_ready = wcnt >= dly;
      wcnt = mem_ready ? 0 : wcnt + 1;
    end else mem_ready = 1'b0;
    if (fetch == 2'b01) ins = mem[mem_addr][7:5];
    if (fetch == 2'b10) op_addr = mem[mem_addr];
  end

  function automatic logic [7:0] rnd_word1();
    logic [2:0] op = 3'($urandom_range(0, 6));
    return {op, 5'($urandom)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; hold = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pc_m = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_f1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fetch == 2'b01) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Runs n instructions; expectations come from the instruction semantics and latency rules
  task automatic run_instrs(input int n, input bit gen);
    bit ok, hlt, ldst;
    logic [7:0] w1, w2, a1, nxt, nx1;
    logic [2:0] op;
    int cyc, f, lat, n_alu, n_sub, n_rw, n_req, n_wr, n_fetch, bad;
    logic [55:0] got, exp;
    for (int k = 0; k < n; k++) begin
      wait_f1(ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL fetch_wait: no word1 capture within 200 cycles, need one at pc=%02h", pc_m);
        return;
      end
      a1 = pc_m + 8'd1; w1 = mem[pc_m]; w2 = mem[a1]; op = w1[7:5];
      hlt = op == 3'd7; ldst = op == 3'd1 || op == 3'd2;
      nxt = (op == 3'd5 || (op == 3'd6 && zero)) ? w2 : pc_m + 8'd2;
      nx1 = nxt + 8'd1;
      lat = hlt ? dly + 4 : 5 + 2 * dly + (op == 3'd2 ? 1 + dly : op == 3'd1 ? 2 + dly : 0);
      cyc = 0; f = -1; n_alu = 0; n_sub = 0; n_rw = 0; n_req = 0; n_wr = 0; n_fetch = 1; bad = 0;
      while (cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (fetch == 2'b01 || halt) break;
        if (fetch == 2'b10) begin
          n_fetch++; f = cyc;
          if (mem_addr !== a1) bad++;
        end
        if (gen && f >= 0 && cyc == f + 1) begin
          mem[nxt] = rnd_word1();
          mem[nx1] = 8'($urandom);
        end
        n_alu += int'(alu_en); n_sub += int'(alu_sub); n_rw += int'(reg_wr);
        if ((mem_rd || mem_wr) && fetch == 2'b00) n_req++;
        if (mem_wr) n_wr++;
        if (mem_rd && mem_wr) bad++;
        if (!busy) bad++;
        if (ldst && f >= 0 && cyc >= f + 2 && cyc <= f + 2 + dly &&
            (mem_addr !== w2 || mem_rd !== (op == 3'd1) || mem_wr !== (op == 3'd2))) bad++;
      end
      checks++;
      if (cyc !== lat) begin
        failures++;
        $display("FAIL latency op=%0d pc=%02h dly=%0d: got %0d cycles, need %0d", op, pc_m, dly, cyc, lat);
      end
      checks++;
      if (pc !== nxt || (!hlt && mem_addr !== nxt)) begin
        failures++;
        $display("FAIL next_pc op=%0d pc=%02h: got pc=%02h addr=%02h, need %02h", op, pc_m, pc, mem_addr, nxt);
      end
      got = {8'(n_alu), 8'(n_sub), 8'(n_rw), 8'(n_req), 8'(n_wr), 8'(n_fetch), 8'(bad)};
      exp = {8'(op == 3'd3 || op == 3'd4), 8'(op == 3'd4), 8'(op == 3'd3 || op == 3'd4 || op == 3'd1),
             8'((dly + 1) * (1 + int'(ldst) + int'(!hlt))), 8'(op == 3'd2 ? dly + 1 : 0), 8'd2, 8'd0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL strobes op=%0d pc=%02h {alu,sub,rw,req,wr,fetch,bad}: got %014h, need %014h", op, pc_m, got, exp);
      end
      pc_m = nxt;
      if (hlt) return;
    end
  endtask

  task automatic test_reset();
    bit ok;
    clear_mem();
    rst = 1'b0; hold = 1'b0; dly = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pc, fetch, mem_rd, mem_wr, mem_addr, alu_en, alu_sub, reg_wr, busy, halt, err} !== 26'd0) begin
      failures++;
      $display("FAIL reset_state: pc=%02h fetch=%b busy=%b halt=%b err=%b addr=%02h, need all 0", pc, fetch, busy, halt, err, mem_addr);
    end
    rst = 1'b1; pc_m = 8'h00;
    pulse_start();
    wait_f1(ok);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (!busy || !mem_rd || mem_addr !== 8'h01 || fetch !== 2'b00) begin
      failures++;
      $display("FAIL stall_f2: busy=%b rd=%b addr=%02h fetch=%b, need 1 1 01 00", busy, mem_rd, mem_addr, fetch);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00 || fetch !== 2'b00 || busy !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: pc=%02h fetch=%b busy=%b rd=%b, need 00 00 0 0", pc, fetch, busy, mem_rd);
    end
    @(negedge clk) rst = 1'b1;
    hold = 1'b0;
    pulse_start();
    wait_f1(ok);
    checks++;
    if (!ok || mem_addr !== 8'h00 || pc !== 8'h00) begin
      failures++;
      $display("FAIL refetch: ok=%b addr=%02h pc=%02h, need 1 00 00", ok, mem_addr, pc);
    end
  endtask

  task automatic test_nop();
    do_reset(); clear_mem(); dly = 0;
    pulse_start();
    run_instrs(2, 1'b0);
  endtask

  task automatic test_load();
    do_reset(); clear_mem(); dly = 3;
    mem[0] = 8'h20; mem[1] = 8'h40;
    pulse_start();
    run_instrs(2, 1'b0);
  endtask

  task automatic test_branch();
    do_reset(); clear_mem(); dly = 1;
    mem[0] = 8'hC0; mem[1] = 8'h10; mem[2] = 8'hC0; mem[3] = 8'h10;
    pulse_start();
    run_instrs(1, 1'b0);
    zero = 1'b1;
    run_instrs(2, 1'b0);
    do_reset(); clear_mem(); dly = 0;
    mem[0] = 8'hA0; mem[1] = 8'hFE; mem[8'hFE] = 8'hA0; mem[8'hFF] = 8'h30;
    pulse_start();
    run_instrs(3, 1'b0);
    do_reset(); mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h00;
    pulse_start();
    run_instrs(3, 1'b0);
  endtask

  task automatic test_halt();
    int bad = 0;
    do_reset(); clear_mem(); dly = 0;
    mem[0] = 8'hE0; mem[1] = 8'h00;
    pulse_start();
    run_instrs(1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      start = i % 5 == 0;
      @(negedge clk);
      if (pc !== pc_m || halt !== 1'b1 || busy !== 1'b0 || fetch !== 2'b00 ||
          {mem_rd, mem_wr, alu_en, reg_wr, err} !== 5'd0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_stable: %0d unstable cycles (pc=%02h halt=%b busy=%b), need 0", bad, pc, halt, busy);
    end
  endtask

  task automatic test_random();
    do_reset(); clear_mem();
    mem[0] = rnd_word1(); mem[1] = 8'($urandom);
    dly = 0;
    pulse_start();
    for (int b = 0; b < 4; b++) begin
      dly = $urandom_range(0, 3);
      zero = 1'($urandom_range(0, 1));
      run_instrs(15, 1'b1);
    end
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset(); clear_mem(); hold = 1'b1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (err) break;
      if (mem_rd) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 15 || err !== 1'b1 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL timeout: err=%b after %0d request cycles rd=%b, need 1 after 15 rd=0", err, n, mem_rd);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: err=%b, need 0", err);
    end
    @(negedge clk) rst = 1'b1;
    hold = 1'b0;
  endtask
`else
  task automatic test_timeout();
    do_reset(); clear_mem(); hold = 1'b1;
    pulse_start();
    repeat (40) @(negedge clk);
    checks++;
    if (err !== 1'b0 || !busy || !mem_rd || mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL no_timeout: err=%b busy=%b rd=%b addr=%02h, need 0 1 1 00", err, busy, mem_rd, mem_addr);
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_nop();
    test_load();
    test_branch();
    test_halt();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
